// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Branch resolution and prediction for the pipelined MIPS datapath.
// The fetch side reads a table of 2-bit saturating counters (the BHT) to
// predict taken/not-taken for the current fetch PC. The execute side
// evaluates the branch condition and drives pc_src. When the outcome differs
// from the prediction carried down the pipe, it raises mispredict and
// supplies the correct next PC. It also trains the BHT and keeps saturating
// statistics counters.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   if_pc             - fetch PC used to index the BHT
//   pred_taken        - prediction for if_pc (MSB of the indexed entry)
//   ex_valid          - EX stage holds a real instruction (0 = bubble)
//   ex_branch         - EX instruction is a conditional branch or jump
//   ex_cond           - branch condition code (BEQ..NEVER)
//   ex_zero, ex_neg   - ALU zero flag and sign bit of rs
//   ex_pc             - PC of the EX instruction
//   ex_pred_taken     - prediction that was made when this branch was fetched
//   ex_target         - computed branch target
//   pc_src            - branch resolved taken
//   mispredict        - flush IF/ID and redirect fetch
//   redirect_pc       - correct next PC while mispredict is high, else 0
//   stat_clr          - synchronous clear of the statistics counters
//   branch_count      - number of resolved branches (saturating)
//   mispredict_count  - number of mispredicted branches (saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int         XLEN       = 32,
    parameter int         BHT_DEPTH  = 16,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_cond,
    input  logic             ex_zero,
    input  logic             ex_neg,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             pc_src,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] COND_BEQ    = 3'b000;
    localparam logic [2:0] COND_BNE    = 3'b001;
    localparam logic [2:0] COND_BLTZ   = 3'b010;
    localparam logic [2:0] COND_BGEZ   = 3'b011;
    localparam logic [2:0] COND_BLEZ   = 3'b100;
    localparam logic [2:0] COND_BGTZ   = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             taken;
    logic             resolve;
    logic [XLEN-1:0]  fallthrough_pc;

    // The word-offset bits and the PC bits above the index take no part in
    // the lookup; folding them here keeps that explicit.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Instructions are word aligned, so the index starts at bit 2. PCs that
    // share these bits deliberately share one history entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // The prediction is a plain table read with no bypass from the EX-side
    // update. A same-index update this cycle shows up on the next cycle.
    assign pred_taken = bht[if_idx][1];

    // Evaluate the branch condition from the ALU flags. The last two codes
    // give unconditional jumps and a never-taken form.
    always_comb begin
        taken = 1'b0;
        case (ex_cond)
            COND_BEQ:    taken = ex_zero;
            COND_BNE:    taken = ~ex_zero;
            COND_BLTZ:   taken = ex_neg;
            COND_BGEZ:   taken = ~ex_neg;
            COND_BLEZ:   taken = ex_neg | ex_zero;
            COND_BGTZ:   taken = ~ex_neg & ~ex_zero;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

    // A bubble never resolves, even when ex_branch is still asserted. The
    // redirect target is the branch target or the sequential PC, whichever
    // the prediction got wrong. The sequential PC wraps naturally at the top
    // of the address space.
    assign resolve        = ex_valid & ex_branch;
    assign pc_src         = resolve & taken;
    assign mispredict     = resolve & (taken != ex_pred_taken);
    assign fallthrough_pc = ex_pc + XLEN'(4);

    always_comb begin
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = taken ? ex_target : fallthrough_pc;
        end
    end

    // Train the entry of the resolving branch. It counts up on taken and down
    // on not-taken, and holds at the ends. A reset returns every entry to the
    // initial weak state. A branch pending in EX at that moment is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= INIT_STATE;
            end
        end else if (resolve) begin
            if (taken) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

    // Statistics counters. A clear wins over an event in the same cycle, and
    // that event is not counted. Both counters stop at all-ones, so a long
    // run reads as "at least this many" and never wraps back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stat_clr) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve && !(&branch_count)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && !(&mispredict_count)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Self-checking bench for branch_predict_unit. It uses 4-bit counters so
// that saturation is reached quickly. It runs directed sequences, a
// condition-code vector table and a randomized run. All of them are compared
// against an array/integer reference model of the predictor.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [2:0] BEQ    = 3'b000;
    localparam logic [2:0] BNE    = 3'b001;
    localparam logic [2:0] ALWAYS = 3'b110;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_cond;
    logic             ex_zero;
    logic             ex_neg;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_target;
    logic             pc_src;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             stat_clr;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: one saturating integer per table slot plus two counts.
    int bhtModel [DEPTH];
    int brModel;
    int mpModel;

    typedef struct {
        logic [2:0] cond;
        logic       zero;
        logic       neg;
        logic       expTaken;
    } vec_t;

    vec_t vecs [24];

    branch_predict_unit #(
        .XLEN       (XLEN),
        .BHT_DEPTH  (DEPTH),
        .INIT_STATE (2'b01),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_cond          (ex_cond),
        .ex_zero          (ex_zero),
        .ex_neg           (ex_neg),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_target        (ex_target),
        .pc_src           (pc_src),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_clr         (stat_clr),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table slot of a PC: its word address modulo the table size.
    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit condTaken(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return n;
            3'd3:    return !n;
            3'd4:    return n || z;
            3'd5:    return !n && !z;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive every input. It is called just after a rising edge and leaves
    // the outputs one time unit to settle before any check.
    task automatic applyStimulus(input logic v, input logic b, input logic [2:0] c,
                                 input logic z, input logic n, input logic [31:0] pc,
                                 input logic pt, input logic [31:0] tgt,
                                 input logic [31:0] ipc, input logic clr);
        ex_valid      = v;
        ex_branch     = b;
        ex_cond       = c;
        ex_zero       = z;
        ex_neg        = n;
        ex_pc         = pc;
        ex_pred_taken = pt;
        ex_target     = tgt;
        if_pc         = ipc;
        stat_clr      = clr;
        #1;
    endtask

    // Compare all outputs against what the model says for the current inputs.
    task automatic checkAll(input string tag);
        bit          res;
        bit          t;
        bit          mp;
        logic [31:0] redir;
        res   = ex_valid && ex_branch;
        t     = condTaken(ex_cond, ex_zero, ex_neg);
        mp    = res && (t != ex_pred_taken);
        redir = 32'd0;
        if (mp) redir = t ? ex_target : ex_pc + 32'd4;
        checkOutput({tag, ".pc_src"},      {31'd0, pc_src},      {31'd0, res && t});
        checkOutput({tag, ".mispredict"},  {31'd0, mispredict},  {31'd0, mp});
        checkOutput({tag, ".redirect_pc"}, redirect_pc,          redir);
        checkOutput({tag, ".pred_taken"},  {31'd0, pred_taken},
                    {31'd0, bhtModel[idxOf(if_pc)] >= 2});
        checkOutput({tag, ".branch_count"},     32'(branch_count),     brModel);
        checkOutput({tag, ".mispredict_count"}, 32'(mispredict_count), mpModel);
    endtask

    // Advance one clock. The model applies the same edge using the inputs
    // that were present before it.
    task automatic tick();
        bit res;
        bit t;
        int i;
        @(posedge clk);
        res = ex_valid && ex_branch;
        t   = condTaken(ex_cond, ex_zero, ex_neg);
        if (stat_clr) begin
            brModel = 0;
            mpModel = 0;
        end else begin
            if (res && brModel < CNT_MAX) brModel++;
            if (res && (t != ex_pred_taken) && mpModel < CNT_MAX) mpModel++;
        end
        if (res) begin
            i = idxOf(ex_pc);
            if (t) bhtModel[i] = (bhtModel[i] == 3) ? 3 : bhtModel[i] + 1;
            else   bhtModel[i] = (bhtModel[i] == 0) ? 0 : bhtModel[i] - 1;
        end
        #1;
    endtask

    // Assert reset away from a clock edge. Check the cleared state, then
    // release with idle inputs and realign to just after a rising edge.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) bhtModel[i] = 1;
        brModel = 0;
        mpModel = 0;
        checkOutput({tag, ".branch_count"},     32'(branch_count),     32'd0);
        checkOutput({tag, ".mispredict_count"}, 32'(mispredict_count), 32'd0);
        ex_valid = 1'b0;
        ex_branch = 1'b0;
        stat_clr = 1'b0;
        for (int a = 0; a <= 32'h3C; a += 4) begin
            if_pc = 32'(a);
            #1;
            checkOutput({tag, ".pred_taken"}, {31'd0, pred_taken}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [2:0] expBits [8];
        vec_t       v;

        // Condition table. Bit p of each entry is the expected taken value
        // for flag pattern p: p0 = (zero 0, neg 0), p1 = (zero 0, neg 1),
        // p2 = (zero 1, neg 0).
        expBits[0] = 3'b100;  // BEQ
        expBits[1] = 3'b011;  // BNE
        expBits[2] = 3'b010;  // BLTZ
        expBits[3] = 3'b101;  // BGEZ
        expBits[4] = 3'b110;  // BLEZ
        expBits[5] = 3'b001;  // BGTZ
        expBits[6] = 3'b111;  // ALWAYS
        expBits[7] = 3'b000;  // NEVER
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 3; p++) begin
                vecs[c*3+p].cond     = 3'(c);
                vecs[c*3+p].zero     = (p == 2);
                vecs[c*3+p].neg      = (p == 1);
                vecs[c*3+p].expTaken = expBits[c][p];
            end
        end

        applyStimulus(0, 0, BEQ, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        doReset("reset");
        checkAll("reset.after");

        // BEQ training at 0x40 (slot 0), starting from weakly not-taken.
        applyStimulus(1, 1, BEQ, 1, 0, 32'h40, 0, 32'h80, 32'h40, 0);
        checkAll("beq1");
        checkOutput("beq1.pc_src_k",      {31'd0, pc_src},     32'd1);
        checkOutput("beq1.mispredict_k",  {31'd0, mispredict}, 32'd1);
        checkOutput("beq1.redirect_k",    redirect_pc,         32'h80);
        tick();
        checkOutput("beq1.pred_after_k",  {31'd0, pred_taken}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, BEQ, 1, 0, 32'h40, 1, 32'h80, 32'h40, 0);
            checkAll("beq_rep");
            tick();
        end
        applyStimulus(1, 1, BEQ, 0, 0, 32'h40, 1, 32'h80, 32'h40, 0);
        checkOutput("beq_nt.redirect_k",  redirect_pc, 32'h44);
        checkAll("beq_nt");
        tick();
        checkOutput("beq_nt.pred_k",      {31'd0, pred_taken}, 32'd1);
        checkOutput("beq_nt.brcnt_k",     32'(branch_count), 32'd4);
        checkOutput("beq_nt.mpcnt_k",     32'(mispredict_count), 32'd2);

        // Not-taken mispredict at the top of memory: fall-through wraps to 0.
        applyStimulus(1, 1, BNE, 1, 0, 32'hFFFF_FFFC, 1, 32'h1234, 32'h0, 0);
        checkOutput("wrap.mispredict_k",  {31'd0, mispredict}, 32'd1);
        checkOutput("wrap.redirect_k",    redirect_pc, 32'h0);
        checkAll("wrap");
        tick();

        // A bubble with ex_branch still high changes nothing.
        applyStimulus(0, 1, ALWAYS, 0, 0, 32'h44, 0, 32'h99, 32'h44, 0);
        checkOutput("bubble.pc_src_k",    {31'd0, pc_src}, 32'd0);
        checkOutput("bubble.mispred_k",   {31'd0, mispredict}, 32'd0);
        checkOutput("bubble.redirect_k",  redirect_pc, 32'd0);
        tick();
        checkOutput("bubble.brcnt_k",     32'(branch_count), 32'd5);
        checkOutput("bubble.mpcnt_k",     32'(mispredict_count), 32'd3);
        checkOutput("bubble.pred_k",      {31'd0, pred_taken}, 32'd0);

        // Same-slot read and write: the old prediction this cycle, the new
        // one on the next cycle.
        applyStimulus(1, 1, ALWAYS, 0, 0, 32'h44, 0, 32'h200, 32'h44, 0);
        checkOutput("collide.pred_now_k", {31'd0, pred_taken}, 32'd0);
        checkAll("collide");
        tick();
        checkOutput("collide.pred_next_k", {31'd0, pred_taken}, 32'd1);

        // Counter saturation and clear priority.
        applyStimulus(0, 0, BEQ, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1);
        tick();
        checkAll("clr");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1, ALWAYS, 0, 0, 32'h100, 0, 32'h300, 32'h100, 0);
            checkAll("sat");
            tick();
        end
        checkOutput("sat.brcnt_k",        32'(branch_count), 32'd15);
        checkOutput("sat.mpcnt_k",        32'(mispredict_count), 32'd15);
        applyStimulus(1, 1, ALWAYS, 0, 0, 32'h100, 0, 32'h300, 32'h100, 1);
        tick();
        checkOutput("clr_pri.brcnt_k",    32'(branch_count), 32'd0);
        checkOutput("clr_pri.mpcnt_k",    32'(mispredict_count), 32'd0);
        applyStimulus(1, 1, ALWAYS, 0, 0, 32'h100, 0, 32'h300, 32'h100, 0);
        tick();
        checkOutput("post_clr.brcnt_k",   32'(branch_count), 32'd1);
        checkAll("post_clr");

        // Reset in the middle of a resolving branch: the table returns to
        // weakly not-taken, including the slot trained above.
        applyStimulus(1, 1, ALWAYS, 0, 0, 32'h100, 0, 32'h300, 32'h100, 0);
        #1;
        doReset("midreset");
        checkAll("midreset.after");

        // Condition sweep from the vector table.
        for (int k = 0; k < 24; k++) begin
            v = vecs[k];
            applyStimulus(1, 1, v.cond, v.zero, v.neg, 32'(k * 4 + 32'h400), 0,
                          32'h5000 + 32'(k), 32'h0, 0);
            checkOutput($sformatf("sweep%0d.pc_src_k", k), {31'd0, pc_src},
                        {31'd0, v.expTaken});
            checkAll($sformatf("sweep%0d", k));
            tick();
        end

        // Randomized run. PCs are mostly drawn from a small window so that
        // fetch and execute often hit the same slot.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] epc;
            logic [31:0] ipc;
            epc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_00FC);
            ipc = ($urandom_range(0, 3) == 0) ? epc : ($urandom & 32'h0000_00FC);
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
                          1'($urandom), 1'($urandom), epc, 1'($urandom), $urandom,
                          ipc, 1'($urandom_range(0, 31) == 0));
            checkAll("rand");
            tick();
            if ($urandom_range(0, 99) == 0) doReset("rand_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
